// File: rtl/cdc_fifo_write_arbiter_pkg.sv
// Shared types and the round-robin pick function for the cdc_fifo write arbiter.
// Requester vectors are zero-padded to RR_MAX_REQ bits before rr_pick is called.
package cdc_fifo_arb_pkg;

   localparam int unsigned RR_MAX_REQ = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   // First set bit of valid scanning upward from last_grant+1, wrapping modulo num_req.
   function automatic int unsigned rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                           input int unsigned           last_grant,
                                           input int unsigned           num_req);
      int unsigned win;
      int unsigned idx;
      logic        found;
      win   = 0;
      found = 1'b0;
      for (int unsigned k = 1; k <= RR_MAX_REQ; k++) begin
         if (k <= num_req) begin
            idx = (last_grant + k) % num_req;
            if (!found && (((valid >> idx) & 16'd1) != 16'd0)) begin
               win   = idx;
               found = 1'b1;
            end
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/cdc_fifo_write_arbiter_if.sv
// Requester handshake and FIFO write-port bundle for cdc_fifo_write_arbiter.
// Build macro CDC_FIFO_ARB_TAG_EN widens fifo_write_data by the requester-ID tag.
interface cdc_fifo_write_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   import cdc_fifo_arb_pkg::*;

   localparam int ID_WIDTH = $clog2(NUM_REQ);
`ifdef CDC_FIFO_ARB_TAG_EN
   localparam int FIFO_WIDTH = DATA_WIDTH + ID_WIDTH;
`else
   localparam int FIFO_WIDTH = DATA_WIDTH;
`endif

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_full;
   logic [FIFO_WIDTH-1:0]         fifo_write_data;
   logic                          fifo_write_increment;
   logic [NUM_REQ-1:0]            grant;
   logic                          busy;

   modport master (
      input  req_valid, req_data, req_last, fifo_full,
      output req_ready, fifo_write_data, fifo_write_increment, grant, busy
   );

   modport slave (
      output req_valid, req_data, req_last, fifo_full,
      input  req_ready, fifo_write_data, fifo_write_increment, grant, busy
   );

endinterface

// File: rtl/cdc_fifo_write_arbiter_rr_priority_select.sv
// Combinational rotating priority encoder: valid vector plus last-winner pointer
// gives the next winner as one-hot and index.
module rr_priority_select
   import cdc_fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [IDW-1:0]     ptr_i,
   output logic [NUM_REQ-1:0] onehot_o,
   output logic [IDW-1:0]     index_o,
   output logic               any_o
);

   logic [RR_MAX_REQ-1:0] valid_pad;

   always_comb begin
      valid_pad                = '0;
      valid_pad[NUM_REQ-1:0]   = valid_i;
      any_o                    = |valid_i;
      index_o                  = IDW'(rr_pick(valid_pad, 32'(ptr_i), NUM_REQ));
      onehot_o                 = any_o ? (NUM_REQ'(1) << index_o) : '0;
   end

endmodule

// File: rtl/cdc_fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one cdc_fifo write port among NUM_REQ requesters.
// Build macro CDC_FIFO_ARB_TAG_EN prefixes each written beat with the granted index.
//
// state | meaning
// IDLE  | no owner; pick next valid requester round-robin, no beat accepted
// BURST | owner fixed; beats pass while FIFO not full until last/limit/withdraw
module cdc_fifo_write_arbiter
   import cdc_fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   cdc_fifo_write_arbiter_if.master bus
);

   localparam int ID_WIDTH = $clog2(NUM_REQ);
   localparam int CW       = $clog2(MAX_BURST + 1);

   arb_state_e          state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [ID_WIDTH-1:0] gidx_q, gidx_d;
   logic [ID_WIDTH-1:0] last_q, last_d;
   logic [CW-1:0]       cnt_q, cnt_d;

   logic [NUM_REQ-1:0]    sel_onehot;
   logic [ID_WIDTH-1:0]   sel_idx;
   logic                  sel_any;
   logic                  g_valid, g_last, accept, burst_end;
   logic [DATA_WIDTH-1:0] g_data;

   rr_priority_select #(.NUM_REQ(NUM_REQ), .IDW(ID_WIDTH)) u_sel (
      .valid_i  (bus.req_valid),
      .ptr_i    (last_q),
      .onehot_o (sel_onehot),
      .index_o  (sel_idx),
      .any_o    (sel_any)
   );

   assign g_valid   = bus.req_valid[gidx_q];
   assign g_last    = bus.req_last[gidx_q];
   assign g_data    = bus.req_data[gidx_q*DATA_WIDTH +: DATA_WIDTH];
   assign accept    = (state_q == BURST) && g_valid && !bus.fifo_full;
   // A withdrawn requester ends the burst even while the FIFO is full.
   assign burst_end = (state_q == BURST) &&
                      (!g_valid || (accept && (g_last || (cnt_q == CW'(MAX_BURST - 1)))));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         last_q  <= ID_WIDTH'(NUM_REQ - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (sel_any) begin
               state_d = BURST;
               grant_d = sel_onehot;
               gidx_d  = sel_idx;
               last_d  = sel_idx;
               cnt_d   = '0;
            end
         end
         BURST: begin
            if (burst_end) begin
               state_d = IDLE;
               grant_d = '0;
               cnt_d   = '0;
            end else if (accept) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = '0;
      if ((state_q == BURST) && !bus.fifo_full) begin
         bus.req_ready[gidx_q] = 1'b1;
      end
      bus.fifo_write_increment = accept;
`ifdef CDC_FIFO_ARB_TAG_EN
      bus.fifo_write_data = {gidx_q, g_data};
`else
      bus.fifo_write_data = g_data;
`endif
      bus.grant = grant_q;
      bus.busy  = (state_q == BURST);
   end

endmodule

// File: tb/tb_cdc_fifo_write_arbiter.sv
// Directed bench for cdc_fifo_write_arbiter; expected beats are queued in arbitration
// order and popped whenever the DUT pulses fifo_write_increment.
module tb_cdc_fifo_write_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
`ifdef CDC_FIFO_ARB_TAG_EN
   localparam int FW = DW + 2;
   localparam logic [FW-1:0] EXP_A5 = 10'h3A5;
`else
   localparam int FW = DW;
   localparam logic [FW-1:0] EXP_A5 = 8'hA5;
`endif

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   cdc_fifo_write_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

   cdc_fifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   int n_inc = 0;
   int m;
   int rem   [NR];
   int seq   [NR];
   int dbase [NR];
   logic [FW-1:0] sb [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_req();
      for (int i = 0; i < NR; i++) begin
         bus.req_valid[i]          = (rem[i] != 0);
         bus.req_last[i]           = (rem[i] == 1);
         bus.req_data[i*DW +: DW]  = DW'(dbase[i] + seq[i]);
      end
   endtask

   task automatic push_beats(input int i, input int first, input int n);
      logic [DW-1:0] d;
      for (int k = 0; k < n; k++) begin
         d = DW'(dbase[i] + first + k);
`ifdef CDC_FIFO_ARB_TAG_EN
         sb.push_back({2'(i), d});
`else
         sb.push_back(d);
`endif
      end
   endtask

   // One clock: check any write at the negedge, then update requesters after the edge.
   task automatic tick();
      logic [NR-1:0] acc;
      @(negedge clock);
      acc = bus.req_valid & bus.req_ready;
      if (bus.fifo_write_increment) begin
         n_inc++;
         if (sb.size() == 0) chk("sb_unexpected_write", 32'(bus.fifo_write_data), 32'hFFFF_FFFF);
         else                chk("sb_data", 32'(bus.fifo_write_data), 32'(sb.pop_front()));
      end
      @(posedge clock);
      #1;
      for (int i = 0; i < NR; i++) begin
         if (acc[i]) begin
            seq[i]++;
            if (rem[i] > 0) rem[i]--;
         end
      end
      apply_req();
   endtask

   task automatic do_reset();
      reset         = 1'b1;
      bus.fifo_full = 1'b0;
      for (int i = 0; i < NR; i++) begin
         rem[i]   = 0;
         seq[i]   = 0;
         dbase[i] = i * 64;
      end
      apply_req();
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      bus.fifo_full = 1'b0;
      for (int i = 0; i < NR; i++) begin
         rem[i] = 0; seq[i] = 0; dbase[i] = i * 64;
      end
      apply_req();
      #1 reset = 1'b1;
      #2;
      chk("rst_grant", 32'(bus.grant), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_ready", 32'(bus.req_ready), 0);
      chk("rst_inc", 32'(bus.fifo_write_increment), 0);
      do_reset();

      // Single requester, 3-beat packet ending on req_last.
      rem[0] = 3;
      push_beats(0, 0, 3);
      apply_req();
      m = n_inc;
      tick();
      chk("t1_grant", 32'(bus.grant), 32'h1);
      chk("t1_busy", 32'(bus.busy), 1);
      chk("t1_ready", 32'(bus.req_ready), 32'h1);
      repeat (3) tick();
      chk("t1_idle_busy", 32'(bus.busy), 0);
      chk("t1_idle_grant", 32'(bus.grant), 0);
      chk("t1_beats", 32'(n_inc - m), 3);
      tick();
      chk("t1_still_idle", 32'(bus.busy), 0);
      chk("t1_sb_empty", 32'(sb.size()), 0);

      // All requesters streaming: MAX_BURST beats each, order 0,1,2,3,0.
      do_reset();
      for (int i = 0; i < NR; i++) rem[i] = -1;
      for (int k = 0; k < 5; k++) push_beats(k % NR, (k / NR) * 4, 4);
      apply_req();
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("t2_grant", 32'(bus.grant), 32'(1 << (k % NR)));
         m = n_inc;
         repeat (4) tick();
         chk("t2_beats", 32'(n_inc - m), 4);
         chk("t2_bubble", 32'(bus.busy), 0);
      end
      for (int i = 0; i < NR; i++) rem[i] = 0;
      apply_req();
      tick();
      chk("t2_end_idle", 32'(bus.busy), 0);
      chk("t2_sb_empty", 32'(sb.size()), 0);

      // FIFO full stalls requester 2 mid-burst for 5 cycles.
      do_reset();
      rem[2] = 4;
      push_beats(2, 0, 4);
      apply_req();
      tick();
      chk("t3_grant", 32'(bus.grant), 32'h4);
      tick();
      bus.fifo_full = 1'b1;
      #1;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("t3_hold_grant", 32'(bus.grant), 32'h4);
         chk("t3_hold_busy", 32'(bus.busy), 1);
         chk("t3_hold_ready", 32'(bus.req_ready), 0);
         chk("t3_hold_inc", 32'(bus.fifo_write_increment), 0);
      end
      bus.fifo_full = 1'b0;
      m = n_inc;
      repeat (3) tick();
      chk("t3_resume_beats", 32'(n_inc - m), 3);
      chk("t3_done", 32'(bus.busy), 0);
      chk("t3_sb_empty", 32'(sb.size()), 0);

      // Requester 0 withdraws after one beat; requester 2 is next.
      do_reset();
      rem[0] = -1;
      rem[2] = -1;
      push_beats(0, 0, 1);
      push_beats(2, 0, 4);
      apply_req();
      tick();
      chk("t4_grant0", 32'(bus.grant), 32'h1);
      tick();
      rem[0] = 0;
      apply_req();
      tick();
      chk("t4_withdraw_busy", 32'(bus.busy), 0);
      chk("t4_withdraw_grant", 32'(bus.grant), 0);
      tick();
      chk("t4_grant2", 32'(bus.grant), 32'h4);
      repeat (4) tick();
      rem[2] = 0;
      apply_req();
      tick();
      chk("t4_done", 32'(bus.busy), 0);
      chk("t4_sb_empty", 32'(sb.size()), 0);

      // Asynchronous reset during beat 2; requester 0 wins again afterwards.
      do_reset();
      for (int i = 0; i < NR; i++) rem[i] = -1;
      push_beats(0, 0, 2);
      apply_req();
      tick();
      chk("t5_grant", 32'(bus.grant), 32'h1);
      repeat (2) tick();
      reset = 1'b1;
      #1;
      chk("t5_async_grant", 32'(bus.grant), 0);
      chk("t5_async_busy", 32'(bus.busy), 0);
      chk("t5_async_ready", 32'(bus.req_ready), 0);
      #1 reset = 1'b0;
      push_beats(0, 2, 4);
      tick();
      chk("t5_post_grant", 32'(bus.grant), 32'h1);
      repeat (4) tick();
      for (int i = 0; i < NR; i++) rem[i] = 0;
      apply_req();
      tick();
      chk("t5_done", 32'(bus.busy), 0);
      chk("t5_sb_empty", 32'(sb.size()), 0);

      // Requester 3 sends 8'hA5 (tagged with ID 3 when the tag build is used).
      do_reset();
      dbase[3] = 8'hA5;
      rem[3]   = 1;
      push_beats(3, 0, 1);
      apply_req();
      tick();
      chk("t6_grant", 32'(bus.grant), 32'h8);
      chk("t6_data", 32'(bus.fifo_write_data), 32'(EXP_A5));
      tick();
      chk("t6_done", 32'(bus.busy), 0);
      chk("t6_sb_empty", 32'(sb.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
